// File: rtl/vga_tile_pkg.sv
// Shared constants and FSM encoding for the VGA tile-map path.
// Used by the sync block, the renderer and the tile-memory arbiter.
package vga_tile_pkg;

  localparam int HD         = 640;
  localparam int VD         = 480;
  localparam int TILE_SHIFT = 5;
  localparam int TILES_X    = 20;
  localparam int TILES_Y    = 15;
  localparam int NUM_TILES  = 300;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/vga_tile_addr.sv
// Combinational pixel coordinate to tile-index mapper.
// The multiply by TILES_X (20) is built as (ty<<4)+(ty<<2), truncated to ADDR_W.
module vga_tile_addr
  import vga_tile_pkg::*;
(
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] tile_addr
);

  logic [ADDR_W-1:0] tx;
  logic [ADDR_W-1:0] ty;

  assign tx        = ADDR_W'(pixel_x >> TILE_SHIFT);
  assign ty        = ADDR_W'(pixel_y >> TILE_SHIFT);
  assign tile_addr = (ty << 4) + (ty << 2) + tx;

endmodule

// File: rtl/vga_tile_mem_arbiter.sv
// Single-port tile-map RAM arbiter: display reads > bulk clear > game writer.
// Optional build macro VBLANK_ONLY_WR_EN restricts writer/clear slots to
// vertical blanking (pixel_y >= VD); display reads are unaffected.
// NOTE: the tile RAM is external and never reset; a reset only aborts the
// clear engine, so entries already written keep their values.
module vga_tile_mem_arbiter
  import vga_tile_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tile_code,
  output logic              tile_valid
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic [ADDR_W-1:0] disp_addr;
  logic              read_slot;
  logic              slot_ok;
  logic              wr_in_range;
  logic              wr_fire;
  logic              clr_fire;
  logic              rd_pend;
  logic              tick_pend;

  vga_tile_addr u_tile_addr (
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .tile_addr (disp_addr)
  );

  assign read_slot = p_tick && video_on;

`ifdef VBLANK_ONLY_WR_EN
  assign slot_ok = !read_slot && (pixel_y >= 10'(VD));
`else
  assign slot_ok = !read_slot;
`endif

  assign wr_in_range = wr_addr < ADDR_W'(NUM_TILES);
  assign wr_fire     = wr_ready && wr_valid;
  assign clr_busy    = (state == CLEAR);

  // State register.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and RAM port mux; the display address is the idle default.
  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    clr_fire  = 1'b0;
    mem_addr  = disp_addr;
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (slot_ok) begin
            wr_ready = 1'b1;
            mem_addr = wr_addr;
            mem_we   = wr_valid && wr_in_range;
          end
          if (clr_start) state_nx = CLEAR;
        end
        CLEAR: begin
          if (slot_ok) begin
            clr_fire  = 1'b1;
            mem_addr  = clr_cnt;
            mem_we    = 1'b1;
            mem_wdata = clr_val;
            if (clr_cnt == ADDR_W'(NUM_TILES - 1)) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Clear engine: latch fill value on start, advance only on granted slots.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clr_cnt <= '0;
      clr_val <= '0;
    end else if (state == IDLE && clr_start) begin
      clr_cnt <= '0;
      clr_val <= clr_value;
    end else if (clr_fire) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Display pipeline: read in N, data in N+1, registered outputs from N+2.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      tick_pend  <= 1'b0;
      tile_code  <= '0;
      tile_valid <= 1'b0;
    end else begin
      rd_pend   <= read_slot;
      tick_pend <= p_tick;
      if (tick_pend) tile_valid <= rd_pend;
      if (rd_pend)   tile_code  <= mem_rdata;
    end
  end

  // One-cycle pulse for an accepted write that falls outside the map.
  always_ff @(posedge CLOCK_50) begin
    if (reset) wr_drop <= 1'b0;
    else       wr_drop <= wr_fire && !wr_in_range;
  end

endmodule
